uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 347, meaning clocks per UART bit (40 MHz / 115200).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width.
REQ-003 SHALL have parameter TERM_WORD, default 32'h0000_0FFF, meaning the end-of-program marker word.
REQ-004 wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 rx_i  input  1  UART serial input (mprj_io[5]), idle high, 8N1 framing.
REQ-007 imem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-008 imem_addr_o  output  ADDR_W  word address of the current write.
REQ-009 imem_wdata_o  output  32  assembled write data.
REQ-010 prog_done_o  output  1  program load complete; drives the core-release and mprj_io[37] ready path.
REQ-011 frame_err_o  output  1  sticky framing-error flag.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer, reset value 1, before any use.
REQ-013 Bit FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-014 IDLE: synchronized rx low SHALL enter START with bit counter cleared.
REQ-015 START: at count CLKS_PER_BIT/2 (integer division), rx low SHALL enter DATA; rx high SHALL return to IDLE with no error (glitch).
REQ-016 DATA: one sample every CLKS_PER_BIT clocks, 8 bits, LSB first; after bit 7 SHALL enter STOP.
REQ-017 STOP: sample after CLKS_PER_BIT clocks; rx high SHALL accept the byte, rx low SHALL set frame_err_o, discard the byte, and leave the byte index unchanged; both cases return to IDLE.
REQ-018 Accepted byte k (k = 0..3) SHALL be placed in word bits [8k+7:8k] (little-endian); the 2-bit byte index SHALL wrap from 3 to 0.
REQ-019 On acceptance of byte 3, if the assembled word equals TERM_WORD, then on the next cycle prog_done_o SHALL go to 1, the FSM SHALL enter DONE, and no write SHALL occur.
REQ-020 Otherwise, on the next cycle imem_we_o SHALL be 1 for exactly one cycle with imem_wdata_o = the word and imem_addr_o = the current address; the address SHALL increment by 1 in the cycle after the strobe.
REQ-021 A write to address 2^ADDR_W-1 SHALL also complete the load: prog_done_o = 1 and DONE in the cycle after the strobe, with no address wrap.
REQ-022 DONE SHALL be absorbing; rx_i activity SHALL be ignored until reset.
REQ-023 imem_addr_o and imem_wdata_o SHALL hold their values between strobes.
REQ-024 A start bit SHALL be detectable in the cycle after a STOP completes (back-to-back frames).

Reset
REQ-025 Asserting wb_rst_i at any time, including mid-frame, SHALL immediately set: FSM = IDLE; byte index = 0; address = 0; imem_we_o = 0; imem_addr_o = 0; imem_wdata_o = 0; prog_done_o = 0; frame_err_o = 0; synchronizer = 1.
REQ-026 A partial word or frame in progress at reset SHALL be discarded.

Configuration
REQ-027 With macro UART_PARITY_EN defined, a PARITY state SHALL follow DATA and expect even parity over the 8 data bits; on mismatch the byte SHALL be discarded and frame_err_o set, then STOP is still sampled.
REQ-028 Without UART_PARITY_EN, framing SHALL be 8N1 and no PARITY state SHALL exist.

Verification (CLKS_PER_BIT = 4, ADDR_W = 4)
REQ-029 Send bytes 13 05 00 00 -> single strobe with addr 0, data 32'h0000_0513; prog_done_o = 0.
REQ-030 Send two words then FF 0F 00 00 -> strobes at addr 0 and 1; prog_done_o = 1; no third strobe; later bytes cause no strobe.
REQ-031 Send byte AA with stop bit held low, then 4 valid bytes -> frame_err_o = 1; the first write carries only the 4 valid bytes.
REQ-032 Pull rx low for 1 clock -> FSM returns to IDLE; frame_err_o = 0; no byte accepted.
REQ-033 Send 16 non-terminator words -> last strobe at addr 15; prog_done_o = 1 in the following cycle.
REQ-034 Assert wb_rst_i after 2 bytes of a word, then send 4 bytes 01 02 03 04 -> strobe at addr 0, data 32'h0403_0201.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver that assembles little-endian 32-bit words and streams them into instruction memory.
// Optional: define UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] TERM_WORD    = 32'h0000_0FFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              prog_done_o,
  output logic              frame_err_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]  HALF     = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t             state;
  logic               rx_meta, rx_sync;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic [1:0]         byte_idx;
  logic [31:0]        word;
  logic [ADDR_W-1:0]  addr;
  logic               word_rdy;
  logic               par_ok;

`ifdef UART_PARITY_EN
  logic par_err;
  assign par_ok = !par_err;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      byte_idx     <= '0;
      word         <= '0;
      addr         <= '0;
      word_rdy     <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      prog_done_o  <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_PARITY_EN
      par_err      <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx_i;
      rx_sync   <= rx_meta;
      word_rdy  <= 1'b0;
      imem_we_o <= 1'b0;

      case (state)
        IDLE: if (!rx_sync) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF) begin
          // A start bit that is high again at mid-bit is treated as a glitch.
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_sync ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == LAST) begin
          cnt     <= '0;
          shift   <= {rx_sync, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
`ifdef UART_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end else cnt <= cnt + 1'b1;
`ifdef UART_PARITY_EN
        PARITY: if (cnt == LAST) begin
          cnt     <= '0;
          par_err <= (rx_sync != ^shift);
          if (rx_sync != ^shift) frame_err_o <= 1'b1;
          state   <= STOP;
        end else cnt <= cnt + 1'b1;
`endif
        STOP: if (cnt == LAST) begin
          cnt   <= '0;
          state <= IDLE;
          if (!rx_sync) frame_err_o <= 1'b1;
          else if (par_ok) begin
            word[{byte_idx, 3'b000} +: 8] <= shift;
            byte_idx <= byte_idx + 1'b1;
            word_rdy <= (byte_idx == 2'd3);
          end
        end else cnt <= cnt + 1'b1;
        DONE: ;
        default: state <= IDLE;
      endcase

      // Word commit runs alongside the bit FSM; entering DONE overrides any frame in flight.
      if (word_rdy) begin
        if (word == TERM_WORD) begin
          prog_done_o <= 1'b1;
          state       <= DONE;
        end else begin
          imem_we_o    <= 1'b1;
          imem_addr_o  <= addr;
          imem_wdata_o <= word;
        end
      end

      if (imem_we_o) begin
        if (addr == ADDR_MAX) begin
          prog_done_o <= 1'b1;
          state       <= DONE;
        end else addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes are queued as frames are sent
// and checked by a strobe monitor.
module tb_uart_prog_loader;
  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          prog_done;
  logic          frame_err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  checks = 0, errors = 0, strobes = 0, cyc = 0;
  int  last_we_cyc = -1, done_cyc = -1;
  logic done_d = 1'b0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TERM_WORD(32'h0000_0FFF)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .prog_done_o(prog_done), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  // Strobe monitor: every write is popped against the scoreboard.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (imem_we === 1'b1) begin
      strobes++;
      last_we_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected addr=%0h data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL strobe_data got addr=%0h data=%h expected addr=%0h data=%h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
    if (prog_done === 1'b1 && done_d !== 1'b1) done_cyc = cyc;
    done_d = prog_done;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    strobes = 0;
    last_we_cyc = -1;
    done_cyc = -1;
    idle(4);
  endtask

  task automatic test_reset();
    do_reset();
    send_byte(8'h5A, 1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, prog_done, frame_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%0h data=%h done=%b ferr=%b expected all zero",
               imem_we, imem_addr, imem_wdata, prog_done, frame_err);
    end
    rst = 1'b0;
    idle(4);
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL reset_no_strobe got %0d expected 0", strobes);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    exp_q.push_back('{addr: 4'd0, data: 32'h0000_0513});
    send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    idle(20);
    checks++;
    if (exp_q.size() != 0 || strobes !== 1) begin
      errors++;
      $display("FAIL single_word got strobes=%0d pending=%0d expected 1/0", strobes, exp_q.size());
    end
    checks++;
    if (prog_done !== 1'b0) begin
      errors++;
      $display("FAIL single_word_done got %b expected 0", prog_done);
    end
    checks++;
    if (imem_addr !== 4'd0 || imem_wdata !== 32'h0000_0513) begin
      errors++;
      $display("FAIL hold_outputs got addr=%0h data=%h expected 0/00000513", imem_addr, imem_wdata);
    end
  endtask

  task automatic test_back_to_back_term();
    do_reset();
    exp_q.push_back('{addr: 4'd0, data: 32'h1122_3344});
    exp_q.push_back('{addr: 4'd1, data: 32'h5566_7788});
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    send_word(32'h0000_0FFF);
    idle(20);
    checks++;
    if (exp_q.size() != 0 || strobes !== 2) begin
      errors++;
      $display("FAIL term_strobes got strobes=%0d pending=%0d expected 2/0", strobes, exp_q.size());
    end
    checks++;
    if (prog_done !== 1'b1) begin
      errors++;
      $display("FAIL term_done got %b expected 1", prog_done);
    end
    send_word(32'hDEAD_BEEF);
    idle(20);
    checks++;
    if (strobes !== 2 || prog_done !== 1'b1) begin
      errors++;
      $display("FAIL done_absorbing got strobes=%0d done=%b expected 2/1", strobes, prog_done);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'hAA, 1'b0);
    idle(3 * CPB);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_set got %b expected 1", frame_err);
    end
    exp_q.push_back('{addr: 4'd0, data: 32'hC0FF_EE11});
    send_word(32'hC0FF_EE11);
    idle(20);
    checks++;
    if (exp_q.size() != 0 || strobes !== 1 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_recover got strobes=%0d pending=%0d ferr=%b expected 1/0/1",
               strobes, exp_q.size(), frame_err);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    @(negedge clk);
    idle(30);
    checks++;
    if (frame_err !== 1'b0 || strobes !== 0) begin
      errors++;
      $display("FAIL glitch got ferr=%b strobes=%0d expected 0/0", frame_err, strobes);
    end
    exp_q.push_back('{addr: 4'd0, data: 32'h8765_4321});
    send_word(32'h8765_4321);
    idle(20);
    checks++;
    if (exp_q.size() != 0 || strobes !== 1) begin
      errors++;
      $display("FAIL glitch_then_word got strobes=%0d pending=%0d expected 1/0", strobes, exp_q.size());
    end
  endtask

  task automatic test_addr_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{addr: 4'(i), data: 32'hA000_0000 + 32'(i)});
      send_word(32'hA000_0000 + 32'(i));
      checks++;
      if (i < 15 && prog_done !== 1'b0) begin
        errors++;
        $display("FAIL early_done word=%0d got %b expected 0", i, prog_done);
      end
    end
    idle(20);
    checks++;
    if (exp_q.size() != 0 || strobes !== 16) begin
      errors++;
      $display("FAIL full_strobes got strobes=%0d pending=%0d expected 16/0", strobes, exp_q.size());
    end
    checks++;
    if (prog_done !== 1'b1 || done_cyc !== last_we_cyc + 1) begin
      errors++;
      $display("FAIL full_done got done=%b done_cyc=%0d expected 1 at cyc %0d",
               prog_done, done_cyc, last_we_cyc + 1);
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(8);
    exp_q.push_back('{addr: 4'd0, data: 32'h0403_0201});
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    idle(20);
    checks++;
    if (exp_q.size() != 0 || strobes !== 1) begin
      errors++;
      $display("FAIL reset_midword got strobes=%0d pending=%0d expected 1/0", strobes, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back_term();
    test_frame_err();
    test_glitch();
    test_addr_full();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
